// File: rtl/dphy_lane_capture.sv
// Circular capture buffer for D-PHY HS lane bytes with selectable trigger and pre-trigger history.
// Readout is re-based so rd_addr 0 returns the oldest sample of the frozen capture.
module dphy_lane_capture #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 1024,
    parameter int PRE_TRIG  = 256,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                     byte_clk,
    input  logic                     rst,
    input  logic                     hs_burst_flag,
    input  logic [8*NUM_LANES-1:0]   lane_data,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [7:0]               trig_pattern,
    input  logic [7:0]               trig_mask,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            trig_pos,
    input  logic [AW-1:0]            rd_addr,
    output logic [8*NUM_LANES:0]     rd_data
);
    localparam int SW     = 8*NUM_LANES + 1;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_N == 0) ? 0 : POST_N - 1);
    localparam logic [AW-1:0] PRE_POS   = AW'(PRE_TRIG);

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   trig_wr_q, trig_wr_d;
    logic            hs_prev_q, hs_prev_d;
    logic            busy_q, done_q;
    logic [AW-1:0]   trig_pos_q;
    logic [SW-1:0]   rd_data_q;
    logic            we;
    logic            trig_hit;
    logic [7:0]      lane0;
    logic [AW-1:0]   rd_phys;

    logic [SW-1:0]   mem [DEPTH];

    assign lane0   = lane_data[7:0];
    assign rd_phys = trig_wr_q - PRE_POS + rd_addr;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit = hs_burst_flag & ~hs_prev_q;
            2'd1:    trig_hit = hs_burst_flag & (((lane0 ^ trig_pattern) & trig_mask) == 8'd0);
            2'd2:    trig_hit = 1'b1;
            default: trig_hit = hs_burst_flag;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        trig_wr_d = trig_wr_q;
        hs_prev_d = hs_prev_q;
        we        = 1'b0;
        if (arm) begin
            // arm overrides everything, including a trigger on the same edge
            wr_ptr_d  = '0;
            cnt_d     = '0;
            hs_prev_d = hs_burst_flag;
            state_d   = (PRE_TRIG == 0) ? WAIT : PRE;
        end else begin
            case (state_q)
                PRE: begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    hs_prev_d = hs_burst_flag;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    hs_prev_d = hs_burst_flag;
                    if (trig_hit) begin
                        trig_wr_d = wr_ptr_q;
                        cnt_d     = '0;
                        state_d   = (POST_N == 0) ? DONE : POST;
                    end
                end
                POST: begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    hs_prev_d = hs_burst_flag;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == POST_LAST) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge byte_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            trig_wr_q  <= '0;
            hs_prev_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trig_pos_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            trig_wr_q  <= trig_wr_d;
            hs_prev_q  <= hs_prev_d;
            busy_q     <= (state_d == PRE) || (state_d == WAIT) || (state_d == POST);
            done_q     <= (state_d == DONE);
            trig_pos_q <= (state_d == DONE) ? PRE_POS : '0;
            rd_data_q  <= mem[rd_phys];
        end
    end

    // sample storage carries no reset; contents are only meaningful once done is set
    always_ff @(posedge byte_clk) begin
        if (we) begin
            mem[wr_ptr_q] <= {hs_burst_flag, lane_data};
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign trig_pos = trig_pos_q;
    assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_dphy_lane_capture.sv
// Directed bench for dphy_lane_capture at DEPTH=16, PRE_TRIG=4, two lanes.
module tb_dphy_lane_capture;
    localparam int NL = 2;
    localparam int DP = 16;
    localparam int PT = 4;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hs = 1'b0;
    logic [8*NL-1:0]   lane = '0;
    logic              arm = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [7:0]        pat = 8'h00;
    logic [7:0]        msk = 8'h00;
    logic              busy, done;
    logic [AW-1:0]     tpos;
    logic [AW-1:0]     raddr = '0;
    logic [8*NL:0]     rdata;

    logic              hs_v [64];
    logic [7:0]        l0_v [64];
    int                errors = 0;
    int                checks = 0;
    int                last;

    dphy_lane_capture #(.NUM_LANES(NL), .DEPTH(DP), .PRE_TRIG(PT)) dut (
        .byte_clk(clk), .rst(rst), .hs_burst_flag(hs), .lane_data(lane), .arm(arm),
        .trig_mode(mode), .trig_pattern(pat), .trig_mask(msk), .busy(busy), .done(done),
        .trig_pos(tpos), .rd_addr(raddr), .rd_data(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic arm_cap(input logic [1:0] m, input logic hs_at_arm);
        mode = m;
        hs   = hs_at_arm;
        lane = '0;
        arm  = 1'b1;
        @(posedge clk); #1;
        arm  = 1'b0;
    endtask

    // drives samples n = 0,1,.. from the vector tables; last = n of the edge that raised done, else -1
    task automatic feed(input int max_n, output int last_n);
        last_n = -1;
        for (int n = 0; n < max_n; n++) begin
            hs   = hs_v[n];
            lane = {l0_v[n] ^ 8'h5A, l0_v[n]};
            @(posedge clk); #1;
            if (done) begin
                last_n = n;
                return;
            end
        end
    endtask

    task automatic read_all(input string tag, input int first);
        for (int i = 0; i < DP; i++) begin
            raddr = AW'(i);
            @(posedge clk); #1;
            check($sformatf("%s rd%0d", tag, i), 32'(rdata),
                  32'({hs_v[first+i], l0_v[first+i] ^ 8'h5A, l0_v[first+i]}));
        end
    endtask

    task automatic fill(input int hs_from, input logic all_hs);
        for (int n = 0; n < 64; n++) begin
            l0_v[n] = 8'(n);
            hs_v[n] = all_hs || (n >= hs_from);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst trig_pos", 32'(tpos), 32'd0);
        check("rst rd_data", 32'(rdata), 32'd0);
        rst = 1'b0;

        // 1: mode0, hs rises at n=10
        fill(10, 1'b0);
        arm_cap(2'd0, 1'b0);
        check("s1 busy after arm", 32'(busy), 32'd1);
        feed(60, last);
        check("s1 done at n", 32'(last), 32'd21);
        check("s1 busy", 32'(busy), 32'd0);
        check("s1 trig_pos", 32'(tpos), 32'(PT));
        read_all("s1", 6);

        // 2: pulse at n=2 inside PRE ignored, real rise at n=8
        fill(8, 1'b0);
        hs_v[2] = 1'b1;
        arm_cap(2'd0, 1'b0);
        feed(60, last);
        check("s2 done at n", 32'(last), 32'd19);
        raddr = 4'd4;
        @(posedge clk); #1;
        check("s2 rd4", 32'(rdata), 32'({1'b1, 8'h08 ^ 8'h5A, 8'h08}));

        // 3: pattern 0xB8 without hs at n=5, with hs at n=9
        fill(99, 1'b0);
        l0_v[5] = 8'hB8;
        l0_v[9] = 8'hB8;
        hs_v[9] = 1'b1;
        pat = 8'hB8;
        msk = 8'hFF;
        arm_cap(2'd1, 1'b0);
        feed(60, last);
        check("s3 done at n", 32'(last), 32'd20);
        raddr = 4'd4;
        @(posedge clk); #1;
        check("s3 rd4", 32'(rdata), 32'({1'b1, 8'hB8 ^ 8'h5A, 8'hB8}));
        raddr = 4'd0;
        @(posedge clk); #1;
        check("s3 rd0", 32'(rdata), 32'({1'b0, 8'hB8 ^ 8'h5A, 8'hB8}));

        // 4: immediate trigger on first WAIT sample
        fill(99, 1'b0);
        arm_cap(2'd2, 1'b0);
        feed(60, last);
        check("s4 done at n", 32'(last), 32'd15);
        read_all("s4", 0);

        // 5: asynchronous reset mid-POST, then repeat scenario 1
        fill(10, 1'b0);
        arm_cap(2'd0, 1'b0);
        feed(14, last);
        check("s5 not done", 32'(last), 32'hFFFFFFFF);
        check("s5 busy pre-rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check("s5 busy async", 32'(busy), 32'd0);
        check("s5 done async", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        arm_cap(2'd0, 1'b0);
        feed(60, last);
        check("s5 done at n", 32'(last), 32'd21);
        raddr = 4'd4;
        @(posedge clk); #1;
        check("s5 rd4", 32'(rdata), 32'({1'b1, 8'h0A ^ 8'h5A, 8'h0A}));

        // 6: hs held high through arm; mode0 never fires, re-arm in WAIT with mode3
        fill(0, 1'b1);
        arm_cap(2'd0, 1'b1);
        feed(40, last);
        check("s6 mode0 no trig", 32'(last), 32'hFFFFFFFF);
        check("s6 busy held", 32'(busy), 32'd1);
        check("s6 done held", 32'(done), 32'd0);
        arm_cap(2'd3, 1'b1);
        feed(60, last);
        check("s6 mode3 done at n", 32'(last), 32'd15);
        read_all("s6", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
